// File: rtl/imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl
//
// Purpose:
//   Boot-time owner of the byte-addressed instruction memory (32-bit words,
//   little endian). Program words arrive over a valid/ready stream and are
//   written sequentially from byte address 0. The core is held (cpu_hold)
//   until the image is in place. After that the memory read port is handed
//   to the fetch stage.
//
// Optional feature macro: CHECKSUM_EN
//   When defined, the ld_last beat carries a 32-bit checksum (sum mod 2^32
//   of all written words) instead of program data. That beat is not written.
//   A wrong checksum, or filling memory without seeing ld_last, ends in ERR.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   boot_start        pulse: start or restart a load (from IDLE/RUN/ERR)
//   ld_valid/ld_data/ld_last/ld_ready   loader stream
//   cpu_fetch_addr    fetch byte address from core
//   cpu_stall_in      pipeline stall from core
//   imem_read_addr    memory read address (fetch address while running)
//   imem_stall        memory stall (core stall while running, else 1)
//   imem_write_addr   memory write address (word aligned, registered)
//   imem_write_data   memory write data (registered)
//   imem_w_en         memory write enable (registered)
//   cpu_hold          1 = core held in reset
//   boot_done         image loaded, core running
//   boot_err          load failed (timeout, or checksum when enabled)
//   words_loaded      words written by the current load (saturating)
// ---------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int INST_MEMORY_SIZE = 1024,
    parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_start,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_fetch_addr,
    input  logic                  cpu_stall_in,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    output logic                  imem_stall,
    output logic [ADDR_WIDTH-1:0] imem_write_addr,
    output logic [31:0]           imem_write_data,
    output logic                  imem_w_en,
    output logic                  cpu_hold,
    output logic                  boot_done,
    output logic                  boot_err,
    output logic [ADDR_WIDTH-2:0] words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Byte address of the final word in memory.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    // Number of words that fit in memory.
    localparam logic [ADDR_WIDTH-2:0] WL_MAX    = {1'b1, {(ADDR_WIDTH-2){1'b0}}};
    localparam logic [TW-1:0]         TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        RUN,
        ERR
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] wp;
    logic [TW-1:0]         idle_cnt;
    logic                  accept;
    logic                  write_beat;
    logic                  at_full;
    logic                  start_load;

`ifdef CHECKSUM_EN
    logic [31:0] sum;
    logic        sum_ok;

    assign sum_ok     = (sum == ld_data);
    // The checksum beat itself is never written to memory.
    assign write_beat = accept && !ld_last;
`else
    assign write_beat = accept;
`endif

    assign accept     = (state == LOAD) && ld_valid;
    assign at_full    = (wp == LAST_ADDR);
    // boot_start is only honoured outside an active load.
    assign start_load = boot_start && ((state == IDLE) || (state == RUN) || (state == ERR));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and ready logic.
    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (boot_start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (accept) begin
`ifdef CHECKSUM_EN
                    if (ld_last) begin
                        next_state = sum_ok ? DRAIN : ERR;
                    end else if (at_full) begin
                        next_state = ERR;
                    end
`else
                    if (ld_last || at_full) begin
                        next_state = DRAIN;
                    end
`endif
                end else if (idle_cnt == TO_LAST) begin
                    next_state = ERR;
                end
            end
            DRAIN: begin
                next_state = RUN;
            end
            RUN, ERR: begin
                if (boot_start) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write pointer, counters and the registered memory write port.
    // wp holds at the final word rather than wrapping; the FSM leaves LOAD
    // on that beat anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp              <= '0;
            words_loaded    <= '0;
            idle_cnt        <= '0;
            imem_w_en       <= 1'b0;
            imem_write_addr <= '0;
            imem_write_data <= '0;
`ifdef CHECKSUM_EN
            sum             <= '0;
`endif
        end else begin
            imem_w_en <= 1'b0;
            if (start_load) begin
                wp           <= '0;
                words_loaded <= '0;
                idle_cnt     <= '0;
`ifdef CHECKSUM_EN
                sum          <= '0;
`endif
            end else if (state == LOAD) begin
                if (accept) begin
                    idle_cnt <= '0;
                    if (write_beat) begin
                        imem_w_en       <= 1'b1;
                        imem_write_addr <= wp;
                        imem_write_data <= ld_data;
                        if (!at_full) begin
                            wp <= wp + ADDR_WIDTH'(4);
                        end
                        if (words_loaded != WL_MAX) begin
                            words_loaded <= words_loaded + (ADDR_WIDTH-1)'(1);
                        end
`ifdef CHECKSUM_EN
                        sum <= sum + ld_data;
`endif
                    end
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

    assign cpu_hold       = (state != RUN);
    assign boot_done      = (state == RUN);
    assign boot_err       = (state == ERR);
    assign imem_read_addr = (state == RUN) ? cpu_fetch_addr : '0;
    assign imem_stall     = (state == RUN) ? cpu_stall_in : 1'b1;

endmodule
